// File: rtl/raster_pkg.sv
// Shared types for the triangle feeder: screen and model coordinates, the
// packing of one triangle in the ROM word, and the feeder FSM states.
package raster_pkg;

  typedef logic [8:0]        coord_t;
  typedef logic signed [9:0] mcoord_t;

  // Screen-space vertex: [2]=x, [1]=y, [0]=z.
  typedef coord_t [2:0] vert_t;

  typedef struct packed {
    mcoord_t x;
    mcoord_t y;
    mcoord_t z;
  } mvert_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_XFORM,
    S_WAIT_RDY,
    S_HOLD
  } feeder_state_t;

  localparam int COORD_BITS = 10;
  localparam int VERT_BITS  = 3 * COORD_BITS;
  localparam int TRI_BITS   = 3 * VERT_BITS;
  localparam int X_LSB      = 2 * COORD_BITS;
  localparam int Y_LSB      = COORD_BITS;
  localparam int Z_LSB      = 0;
  localparam int ADDR_BITS  = 10;
  localparam logic signed [10:0] Z_MAX = 11'sd511;

  // ROM word is {v3,v2,v1}, so vertex n sits at n*VERT_BITS.
  function automatic mvert_t unpack_vert(input logic [TRI_BITS-1:0] word, input int n);
    logic [VERT_BITS-1:0] v;
    mvert_t r;
    v   = word[n*VERT_BITS +: VERT_BITS];
    r.x = v[X_LSB +: COORD_BITS];
    r.y = v[Y_LSB +: COORD_BITS];
    r.z = v[Z_LSB +: COORD_BITS];
    return r;
  endfunction

  function automatic coord_t clamp_coord(input logic signed [10:0] v,
                                         input logic signed [10:0] hi);
    coord_t r;
    if (v[10])       r = '0;
    else if (v > hi) r = hi[8:0];
    else             r = v[8:0];
    return r;
  endfunction

endpackage

// File: rtl/tri_feeder_vertex_xform.sv
// Offset-and-clamp for one model-space vertex. Purely combinational so the
// feeder can register all three transformed vertices in a single cycle.
module vertex_xform
  import raster_pkg::*;
#(
  parameter int WIDTH  = 360,
  parameter int HEIGHT = 360
) (
  input  mvert_t  i_vert,
  input  mcoord_t i_x_off,
  input  mcoord_t i_y_off,
  output vert_t   o_vert
);

  localparam logic signed [10:0] X_MAX = 11'(WIDTH - 1);
  localparam logic signed [10:0] Y_MAX = 11'(HEIGHT - 1);

  logic signed [10:0] w_x_sum;
  logic signed [10:0] w_y_sum;
  logic signed [10:0] w_z_ext;

  // 11-bit sums of two 10-bit signed operands can never overflow.
  assign w_x_sum = {i_vert.x[9], i_vert.x} + {i_x_off[9], i_x_off};
  assign w_y_sum = {i_vert.y[9], i_vert.y} + {i_y_off[9], i_y_off};
  assign w_z_ext = {i_vert.z[9], i_vert.z};

  assign o_vert[2] = clamp_coord(w_x_sum, X_MAX);
  assign o_vert[1] = clamp_coord(w_y_sum, Y_MAX);
  assign o_vert[0] = clamp_coord(w_z_ext, Z_MAX);

endmodule

// File: rtl/tri_feeder.sv
// Triangle feeder: walks the object's triangle ROM once per frame, offsets and
// clamps each vertex, and hands triangles to the rasterizer one at a time.
// Define BACKFACE_CULL_EN to drop back-facing triangles and expose cull_count.
module tri_feeder
  import raster_pkg::*;
#(
  parameter int WIDTH       = 360,
  parameter int HEIGHT      = 360,
  parameter int NUM_TRIS    = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 new_frame,
  input  mcoord_t              x_off,
  input  mcoord_t              y_off,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [TRI_BITS-1:0]  mem_data,
  input  logic                 rast_ready,
  output vert_t                vert1,
  output vert_t                vert2,
  output vert_t                vert3,
  output logic                 valid_tri,
  output logic                 obj_done,
  output logic                 busy,
  output logic                 frame_overrun
`ifdef BACKFACE_CULL_EN
  ,
  output logic [10:0]          cull_count
`endif
);

  localparam bit HAS_TRIS = (NUM_TRIS > 0);
  localparam int LAST_I   = HAS_TRIS ? NUM_TRIS - 1 : 0;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = LAST_I[ADDR_BITS-1:0];
  localparam int LAT_W    = $clog2(MEM_LATENCY + 1) + 1;
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LATENCY);

  feeder_state_t         r_state;
  feeder_state_t         w_next_state;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [LAT_W-1:0]      r_lat;
  mcoord_t               r_x_off;
  mcoord_t               r_y_off;
  logic [TRI_BITS-1:0]   r_raw;
  vert_t                 r_vert1;
  vert_t                 r_vert2;
  vert_t                 r_vert3;
  logic                  r_overrun;

  logic                  w_last;
  logic                  w_accept;
  logic                  w_cull;
  mvert_t                w_raw1;
  mvert_t                w_raw2;
  mvert_t                w_raw3;
  vert_t                 w_xf1;
  vert_t                 w_xf2;
  vert_t                 w_xf3;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = new_frame && HAS_TRIS;

  assign w_raw1 = unpack_vert(r_raw, 0);
  assign w_raw2 = unpack_vert(r_raw, 1);
  assign w_raw3 = unpack_vert(r_raw, 2);

  vertex_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xf1 (
    .i_vert (w_raw1),
    .i_x_off(r_x_off),
    .i_y_off(r_y_off),
    .o_vert (w_xf1)
  );

  vertex_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xf2 (
    .i_vert (w_raw2),
    .i_x_off(r_x_off),
    .i_y_off(r_y_off),
    .o_vert (w_xf2)
  );

  vertex_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xf3 (
    .i_vert (w_raw3),
    .i_x_off(r_x_off),
    .i_y_off(r_y_off),
    .o_vert (w_xf3)
  );

`ifdef BACKFACE_CULL_EN
  logic signed [9:0]  w_dx21;
  logic signed [9:0]  w_dy31;
  logic signed [9:0]  w_dy21;
  logic signed [9:0]  w_dx31;
  logic signed [19:0] w_p1;
  logic signed [19:0] w_p2;
  logic signed [20:0] w_area;
  logic [10:0]        r_cull_count;

  // Signed area on clamped coords; zero or negative means back-facing or degenerate.
  assign w_dx21 = $signed({1'b0, w_xf2[2]}) - $signed({1'b0, w_xf1[2]});
  assign w_dy31 = $signed({1'b0, w_xf3[1]}) - $signed({1'b0, w_xf1[1]});
  assign w_dy21 = $signed({1'b0, w_xf2[1]}) - $signed({1'b0, w_xf1[1]});
  assign w_dx31 = $signed({1'b0, w_xf3[2]}) - $signed({1'b0, w_xf1[2]});
  assign w_p1   = w_dx21 * w_dy31;
  assign w_p2   = w_dy21 * w_dx31;
  assign w_area = {w_p1[19], w_p1} - {w_p2[19], w_p2};
  assign w_cull = (w_area[20] || (w_area == '0)) && !w_last;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cull_count <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_cull_count <= '0;
    end else if (r_state == S_XFORM && w_cull) begin
      r_cull_count <= r_cull_count + 1'b1;
    end
  end

  assign cull_count = r_cull_count;
`else
  assign w_cull = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next_state = S_FETCH;
      S_FETCH:    if (r_lat == LAT_END) w_next_state = S_XFORM;
      S_XFORM:    w_next_state = w_cull ? S_HOLD : S_WAIT_RDY;
      S_WAIT_RDY: if (rast_ready) w_next_state = S_HOLD;
      S_HOLD:     w_next_state = w_last ? S_IDLE : S_FETCH;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // The valid pulse is taken straight from rast_ready; HOLD then masks its stale copy.
  always_comb begin
    valid_tri = 1'b0;
    obj_done  = 1'b0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_WAIT_RDY && rast_ready && !rst_in) begin
      valid_tri = 1'b1;
      obj_done  = w_last;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_idx     <= '0;
      r_lat     <= '0;
      r_x_off   <= '0;
      r_y_off   <= '0;
      r_raw     <= '0;
      r_vert1   <= '0;
      r_vert2   <= '0;
      r_vert3   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (new_frame && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= '0;
            r_lat   <= '0;
            r_x_off <= x_off;
            r_y_off <= y_off;
          end
        end
        S_FETCH: begin
          if (r_lat == LAT_END) begin
            r_raw <= mem_data;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_XFORM: begin
          r_vert1 <= w_xf1;
          r_vert2 <= w_xf2;
          r_vert3 <= w_xf3;
        end
        S_HOLD: begin
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
            r_lat <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr      = r_idx;
  assign vert1         = r_vert1;
  assign vert2         = r_vert2;
  assign vert3         = r_vert3;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_tri_feeder.sv
// Self-checking bench for tri_feeder: randomized and directed frames checked by
// a scoreboard fed from an arithmetic model of the offset/clamp/cull rules.
`timescale 1ns/1ps
module tb_tri_feeder;
  import raster_pkg::*;

  localparam int NT  = 4;
  localparam int LAT = 3;

  typedef struct {
    vert_t v1;
    vert_t v2;
    vert_t v3;
    logic  done;
  } expTri_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        newFrame;
  mcoord_t     xOff;
  mcoord_t     yOff;
  logic [9:0]  memAddr;
  logic [9:0]  memAddr0;
  logic [89:0] memData;
  logic        rastReady;
  vert_t       vert1, vert2, vert3;
  vert_t       vert10, vert20, vert30;
  logic        validTri, objDone, busy, overrun;
  logic        validTri0, objDone0, busy0, overrun0;
`ifdef BACKFACE_CULL_EN
  logic [10:0] cullCount;
  logic [10:0] cullCount0;
`endif

  logic [89:0] rom [NT];
  logic [9:0]  addrPipe [LAT];
  expTri_t     expQ[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          expCull     = 0;
  int          pushed      = 0;
  int          readyMode   = 0;

  always #5 clk = ~clk;

  tri_feeder #(.WIDTH(360), .HEIGHT(360), .NUM_TRIS(NT), .MEM_LATENCY(LAT)) dut (
    .clk_in(clk), .rst_in(rst), .new_frame(newFrame), .x_off(xOff), .y_off(yOff),
    .mem_addr(memAddr), .mem_data(memData), .rast_ready(rastReady),
    .vert1(vert1), .vert2(vert2), .vert3(vert3), .valid_tri(validTri),
    .obj_done(objDone), .busy(busy), .frame_overrun(overrun)
`ifdef BACKFACE_CULL_EN
    , .cull_count(cullCount)
`endif
  );

  tri_feeder #(.WIDTH(360), .HEIGHT(360), .NUM_TRIS(0), .MEM_LATENCY(LAT)) dut0 (
    .clk_in(clk), .rst_in(rst), .new_frame(newFrame), .x_off(xOff), .y_off(yOff),
    .mem_addr(memAddr0), .mem_data(memData), .rast_ready(rastReady),
    .vert1(vert10), .vert2(vert20), .vert3(vert30), .valid_tri(validTri0),
    .obj_done(objDone0), .busy(busy0), .frame_overrun(overrun0)
`ifdef BACKFACE_CULL_EN
    , .cull_count(cullCount0)
`endif
  );

  // ROM with LAT cycles from address to data.
  always @(posedge clk) begin
    addrPipe[0] <= memAddr;
    for (int i = 1; i < LAT; i++) addrPipe[i] <= addrPipe[i-1];
  end
  assign memData = (int'(addrPipe[LAT-1]) < NT) ? rom[addrPipe[LAT-1][1:0]] : '0;

  initial begin
    rastReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       rastReady = 1'b1;
        1:       rastReady = 1'($urandom % 2);
        default: rastReady = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampI(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic vert_t modelVert(input logic [29:0] raw, input int xo, input int yo);
    logic signed [9:0] sx, sy, sz;
    vert_t r;
    sx = raw[29:20];
    sy = raw[19:10];
    sz = raw[9:0];
    r[2] = 9'(clampI(int'(sx) + xo, 359));
    r[1] = 9'(clampI(int'(sy) + yo, 359));
    r[0] = 9'(clampI(int'(sz), 511));
    return r;
  endfunction

  function automatic int areaOf(input vert_t a, input vert_t b, input vert_t c);
    return (int'(b[2]) - int'(a[2])) * (int'(c[1]) - int'(a[1]))
         - (int'(b[1]) - int'(a[1])) * (int'(c[2]) - int'(a[2]));
  endfunction

  function automatic logic [29:0] packVert(input int x, input int y, input int z);
    return {10'(x), 10'(y), 10'(z)};
  endfunction

  function automatic logic [89:0] basicTri(input bit cw);
    if (cw) return {packVert(10, 0, 5), packVert(0, 10, 5), packVert(0, 0, 5)};
    return {packVert(0, 10, 5), packVert(10, 0, 5), packVert(0, 0, 5)};
  endfunction

  // Pushes the model's view of the whole walk, then issues the new_frame pulse.
  task automatic applyStimulus(input int xo, input int yo);
    expTri_t e;
    expCull = 0;
    pushed  = 0;
    for (int t = 0; t < NT; t++) begin
      e.v1   = modelVert(rom[t][29:0], xo, yo);
      e.v2   = modelVert(rom[t][59:30], xo, yo);
      e.v3   = modelVert(rom[t][89:60], xo, yo);
      e.done = (t == NT - 1);
`ifdef BACKFACE_CULL_EN
      if (areaOf(e.v1, e.v2, e.v3) <= 0 && t != NT - 1) begin
        expCull++;
        continue;
      end
`endif
      expQ.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    xOff     = 10'(xo);
    yOff     = 10'(yo);
    newFrame = 1'b1;
    @(posedge clk); #1;
    newFrame = 1'b0;
  endtask

  task automatic finishFrame(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 800) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s_idle", name), busy, 0);
    checkOutput($sformatf("%s_drained", name), expQ.size(), 0);
`ifdef BACKFACE_CULL_EN
    checkOutput($sformatf("%s_cull_count", name), cullCount, expCull);
`endif
    @(posedge clk); #1;
  endtask

  task automatic randomRom();
    for (int t = 0; t < NT; t++) rom[t] = 90'({$urandom, $urandom, $urandom});
  endtask

  function automatic int randOff();
    logic signed [9:0] r;
    r = 10'($urandom);
    return int'(r);
  endfunction

  // Scoreboard monitor: pops one expected triangle per valid_tri.
  always @(negedge clk) begin
    expTri_t e;
    if (validTri) begin
      checkOutput("valid_needs_ready", rastReady, 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid_tri", validTri, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("vert1", vert1, e.v1);
        checkOutput("vert2", vert2, e.v2);
        checkOutput("vert3", vert3, e.v3);
        checkOutput("obj_done", objDone, e.done);
      end
    end else if (objDone) begin
      checkOutput("obj_done_without_valid", objDone, 0);
    end
    if (validTri0 || busy0) begin
      checkOutput("ntris0_valid", validTri0, 0);
      checkOutput("ntris0_busy", busy0, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", nCompared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    newFrame = 1'b0;
    xOff     = '0;
    yOff     = '0;
    for (int t = 0; t < NT; t++) rom[t] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_mem_addr", memAddr, 0);
    checkOutput("reset_vert1", vert1, 0);
    checkOutput("reset_vert2", vert2, 0);
    checkOutput("reset_vert3", vert3, 0);
    checkOutput("reset_valid_tri", validTri, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    @(posedge clk); #1;

    $display("[TB] basic walk with offsets (180,180)");
    for (int t = 0; t < NT; t++) rom[t] = basicTri(1'b0);
    applyStimulus(180, 180);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("first_pulse_cycle%0d", k), validTri, (k == 6));
      if (k == 1) checkOutput("busy_after_new_frame", busy, 1);
      @(posedge clk); #1;
    end
    finishFrame("basic");

    $display("[TB] clamp boundaries");
    randomRom();
    rom[0] = {packVert(359, 0, 0), packVert(400, -300, 511), packVert(-300, 400, -4)};
    rom[1] = {packVert(-512, 511, 1), packVert(0, 359, 360), packVert(511, -512, -512)};
    applyStimulus(0, 0);
    finishFrame("clamp");

    $display("[TB] rast_ready held low");
    randomRom();
    readyMode = 2;
    applyStimulus(randOff(), randOff());
    repeat (30) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_nothing_popped", expQ.size(), pushed);
    checkOutput("stall_busy", busy, 1);
    readyMode = 0;
    finishFrame("stall");

    $display("[TB] new_frame during walk");
    randomRom();
    applyStimulus(randOff(), randOff());
    repeat (8) @(posedge clk);
    #1 xOff = 10'sd300;
    yOff     = -10'sd300;
    newFrame = 1'b1;
    @(posedge clk); #1 newFrame = 1'b0;
    finishFrame("overrun");
    checkOutput("overrun_sticky", overrun, 1);

    $display("[TB] reset in FETCH");
    randomRom();
    applyStimulus(randOff(), randOff());
    @(posedge clk); #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_overrun", overrun, 0);
    checkOutput("midreset_mem_addr", memAddr, 0);
    checkOutput("midreset_vert1", vert1, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_still_idle", busy, 0);
    @(posedge clk); #1;

    $display("[TB] new_frame on the last HOLD cycle");
    for (int t = 0; t < NT; t++) rom[t] = basicTri(1'b0);
    applyStimulus(10, 20);
    for (int k = 1; k <= 29; k++) begin
      newFrame = (k == 7 * NT);
      @(negedge clk);
      if (k == 7 * NT) checkOutput("busy_last_hold", busy, 1);
      if (k == 7 * NT + 1) checkOutput("busy_after_walk", busy, 0);
      @(posedge clk); #1;
    end
    newFrame = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("coincident_no_new_walk", busy, 0);
    checkOutput("coincident_drained", expQ.size(), 0);
    checkOutput("coincident_overrun", overrun, 1);
    @(posedge clk); #1;

    $display("[TB] winding mix");
    rom[0] = basicTri(1'b0);
    rom[1] = basicTri(1'b1);
    rom[2] = basicTri(1'b0);
    rom[3] = basicTri(1'b1);
    applyStimulus(50, 60);
    finishFrame("winding");

    $display("[TB] randomized frames");
    readyMode = 1;
    for (int f = 0; f < 20; f++) begin
      randomRom();
      applyStimulus(randOff(), randOff());
      finishFrame($sformatf("rand%0d", f));
    end
    readyMode = 0;

    @(negedge clk);
    checkOutput("ntris0_overrun", overrun0, 0);
    checkOutput("ntris0_busy_end", busy0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
